// File: rtl/gpr_wb_arbiter.sv
// Round-robin arbiter sharing the general_reg write port between ALU and LSU writeback,
// with a pending-write scoreboard for RAW hazard detection at issue.
module gpr_wb_arbiter #(
    parameter int unsigned XLEN    = 32,
    parameter bit          RR_INIT = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_hold,
    input  logic            i_alu_valid,
    input  logic [4:0]      i_alu_addr,
    input  logic [XLEN-1:0] i_alu_data,
    output logic            o_alu_ready,
    input  logic            i_lsu_valid,
    input  logic [4:0]      i_lsu_addr,
    input  logic [XLEN-1:0] i_lsu_data,
    output logic            o_lsu_ready,
    input  logic            i_issue_flag,
    input  logic [4:0]      i_issue_addr,
    output logic            o_write_flag,
    output logic [4:0]      o_write_addr,
    output logic [XLEN-1:0] o_write_data,
    output logic [31:0]     o_pending
);

    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 32;

    logic            r_rr_ptr;
    logic            r_write_flag;
    logic [AW-1:0]   r_write_addr;
    logic [XLEN-1:0] r_write_data;
    logic [NREG-1:0] r_pending;

    logic            w_alu_grant;
    logic            w_lsu_grant;
    logic            w_grant;
    logic            w_conflict;
    logic [AW-1:0]   w_gnt_addr;
    logic [XLEN-1:0] w_gnt_data;
    logic [NREG-1:0] w_pending_nxt;

    // Grant selection: depends only on valids, hold, reset and the round-robin pointer.
    always_comb begin
        w_alu_grant = 1'b0;
        w_lsu_grant = 1'b0;
        if (rst && !i_hold) begin
            if (i_alu_valid && (!i_lsu_valid || !r_rr_ptr)) begin
                w_alu_grant = 1'b1;
            end else if (i_lsu_valid) begin
                w_lsu_grant = 1'b1;
            end
        end
    end

    assign w_grant     = w_alu_grant | w_lsu_grant;
    assign w_conflict  = i_alu_valid & i_lsu_valid;
    assign w_gnt_addr  = w_alu_grant ? i_alu_addr : i_lsu_addr;
    assign w_gnt_data  = w_alu_grant ? i_alu_data : i_lsu_data;
    assign o_alu_ready = w_alu_grant;
    assign o_lsu_ready = w_lsu_grant;

    // Scoreboard: a same-cycle issue to the granted register is younger, so set wins over clear.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_grant) begin
            w_pending_nxt[w_gnt_addr] = 1'b0;
        end
        if (i_issue_flag && (i_issue_addr != '0)) begin
            w_pending_nxt[i_issue_addr] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr     <= RR_INIT;
            r_write_flag <= 1'b0;
            r_write_addr <= '0;
            r_write_data <= '0;
            r_pending    <= '0;
        end else begin
            r_write_flag <= w_grant && (w_gnt_addr != '0);
            if (w_grant && (w_gnt_addr != '0)) begin
                r_write_addr <= w_gnt_addr;
                r_write_data <= w_gnt_data;
            end
            // Pointer moves only on contested grants, to the loser.
            if (w_grant && w_conflict) begin
                r_rr_ptr <= w_alu_grant;
            end
            r_pending <= w_pending_nxt;
        end
    end

    assign o_write_flag = r_write_flag;
    assign o_write_addr = r_write_addr;
    assign o_write_data = r_write_data;
    assign o_pending    = r_pending;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed table-driven bench for gpr_wb_arbiter plus hand-written reset sequences.
module tb_gpr_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        i_hold;
    logic        i_alu_valid;
    logic [4:0]  i_alu_addr;
    logic [31:0] i_alu_data;
    logic        o_alu_ready;
    logic        i_lsu_valid;
    logic [4:0]  i_lsu_addr;
    logic [31:0] i_lsu_data;
    logic        o_lsu_ready;
    logic        i_issue_flag;
    logic [4:0]  i_issue_addr;
    logic        o_write_flag;
    logic [4:0]  o_write_addr;
    logic [31:0] o_write_data;
    logic [31:0] o_pending;

    int total;
    int bad;

    gpr_wb_arbiter #(.XLEN(32), .RR_INIT(1'b0)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_hold       (i_hold),
        .i_alu_valid  (i_alu_valid),
        .i_alu_addr   (i_alu_addr),
        .i_alu_data   (i_alu_data),
        .o_alu_ready  (o_alu_ready),
        .i_lsu_valid  (i_lsu_valid),
        .i_lsu_addr   (i_lsu_addr),
        .i_lsu_data   (i_lsu_data),
        .o_lsu_ready  (o_lsu_ready),
        .i_issue_flag (i_issue_flag),
        .i_issue_addr (i_issue_addr),
        .o_write_flag (o_write_flag),
        .o_write_addr (o_write_addr),
        .o_write_data (o_write_data),
        .o_pending    (o_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hold;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        iv;
        logic [4:0]  ia;
        logic        e_ar;
        logic        e_lr;
        logic        e_wf;
        logic        chk_ad;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic [31:0] e_pend;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic hold, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld,
                       input logic iv, input logic [4:0] ia,
                       input logic e_ar, input logic e_lr, input logic e_wf, input logic chk_ad,
                       input logic [4:0] e_wa, input logic [31:0] e_wd, input logic [31:0] e_pend);
        vec_t v;
        v.hold = hold; v.av = av; v.aa = aa; v.ad = ad;
        v.lv = lv; v.la = la; v.ld = ld; v.iv = iv; v.ia = ia;
        v.e_ar = e_ar; v.e_lr = e_lr; v.e_wf = e_wf; v.chk_ad = chk_ad;
        v.e_wa = e_wa; v.e_wd = e_wd; v.e_pend = e_pend;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic hold, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld,
                         input logic iv, input logic [4:0] ia);
        i_hold = hold; i_alu_valid = av; i_alu_addr = aa; i_alu_data = ad;
        i_lsu_valid = lv; i_lsu_addr = la; i_lsu_data = ld;
        i_issue_flag = iv; i_issue_addr = ia;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        //  hold av aa  ad            lv la  ld           iv ia  ar lr wf ck wa  wd            pend
        add(0, 1, 5,  32'hDEADBEEF, 0, 0,  0,           0, 0,  1, 0, 1, 1, 5,  32'hDEADBEEF, 32'h0);
        add(0, 0, 0,  0,            0, 0,  0,           0, 0,  0, 0, 0, 1, 5,  32'hDEADBEEF, 32'h0);
        add(0, 1, 1,  32'h101,      1, 11, 32'h111,     0, 0,  1, 0, 1, 1, 1,  32'h101,      32'h0);
        add(0, 1, 2,  32'h102,      1, 11, 32'h111,     0, 0,  0, 1, 1, 1, 11, 32'h111,      32'h0);
        add(0, 1, 2,  32'h102,      1, 12, 32'h112,     0, 0,  1, 0, 1, 1, 2,  32'h102,      32'h0);
        add(0, 1, 3,  32'h103,      1, 12, 32'h112,     0, 0,  0, 1, 1, 1, 12, 32'h112,      32'h0);
        add(1, 1, 3,  32'h103,      1, 13, 32'h113,     0, 0,  0, 0, 0, 1, 12, 32'h112,      32'h0);
        add(0, 1, 3,  32'h103,      1, 13, 32'h113,     0, 0,  1, 0, 1, 1, 3,  32'h103,      32'h0);
        add(0, 0, 0,  0,            1, 13, 32'h113,     0, 0,  0, 1, 1, 1, 13, 32'h113,      32'h0);
        add(0, 1, 4,  32'h104,      1, 14, 32'h114,     0, 0,  0, 1, 1, 1, 14, 32'h114,      32'h0);
        add(0, 1, 4,  32'h104,      0, 0,  0,           0, 0,  1, 0, 1, 1, 4,  32'h104,      32'h0);
        add(0, 1, 6,  32'h106,      1, 15, 32'h115,     0, 0,  1, 0, 1, 1, 6,  32'h106,      32'h0);
        add(0, 0, 0,  0,            1, 15, 32'h115,     0, 0,  0, 1, 1, 1, 15, 32'h115,      32'h0);
        add(0, 0, 0,  0,            1, 0,  32'hABC,     0, 0,  0, 1, 0, 0, 0,  32'h0,        32'h0);
        add(0, 1, 9,  32'h109,      0, 0,  0,           1, 7,  1, 0, 1, 1, 9,  32'h109,      32'h80);
        add(0, 0, 0,  0,            0, 0,  0,           1, 0,  0, 0, 0, 1, 9,  32'h109,      32'h80);
        add(0, 1, 7,  32'h107,      0, 0,  0,           1, 9,  1, 0, 1, 1, 7,  32'h107,      32'h200);
        add(0, 1, 7,  32'h777,      0, 0,  0,           1, 7,  1, 0, 1, 1, 7,  32'h777,      32'h280);
        add(1, 1, 9,  32'h999,      0, 0,  0,           1, 9,  0, 0, 0, 1, 7,  32'h777,      32'h280);
        add(0, 1, 9,  32'h999,      0, 0,  0,           0, 0,  1, 0, 1, 1, 9,  32'h999,      32'h80);
        add(0, 0, 0,  0,            1, 7,  32'h7777,    0, 0,  0, 1, 1, 1, 7,  32'h7777,     32'h0);
        add(0, 0, 0,  0,            1, 8,  32'h888,     1, 8,  0, 1, 1, 1, 8,  32'h888,      32'h100);

        // Reset state while reset is held
        #12;
        chk("rst_wf",   -1, 32'(o_write_flag), 32'h0);
        chk("rst_wa",   -1, 32'(o_write_addr), 32'h0);
        chk("rst_wd",   -1, o_write_data, 32'h0);
        chk("rst_pend", -1, o_pending, 32'h0);
        i_alu_valid = 1'b1;
        #1;
        chk("rst_ready", -1, 32'(o_alu_ready), 32'h0);
        i_alu_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].hold, vecs[i].av, vecs[i].aa, vecs[i].ad,
                  vecs[i].lv, vecs[i].la, vecs[i].ld, vecs[i].iv, vecs[i].ia);
            #1;
            chk("alu_ready", i, 32'(o_alu_ready), 32'(vecs[i].e_ar));
            chk("lsu_ready", i, 32'(o_lsu_ready), 32'(vecs[i].e_lr));
            @(posedge clk);
            #1;
            chk("write_flag", i, 32'(o_write_flag), 32'(vecs[i].e_wf));
            if (vecs[i].chk_ad) begin
                chk("write_addr", i, 32'(o_write_addr), 32'(vecs[i].e_wa));
                chk("write_data", i, o_write_data, vecs[i].e_wd);
            end
            chk("pending", i, o_pending, vecs[i].e_pend);
        end

        // Async reset mid-transfer: registered write and scoreboard drop without a clock edge
        @(negedge clk);
        drive(0, 1, 20, 32'hCAFE, 0, 0, 0, 1, 3);
        @(posedge clk);
        #1;
        chk("mid_wf_pre",   100, 32'(o_write_flag), 32'h1);
        chk("mid_pend_pre", 100, o_pending, 32'h108);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_wf_rst",    101, 32'(o_write_flag), 32'h0);
        chk("mid_pend_rst",  101, o_pending, 32'h0);
        chk("mid_ready_rst", 101, 32'(o_alu_ready), 32'h0);

        // Pointer was 1 before reset; after reset ALU must win the first conflict
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1, 21, 32'h2121, 1, 22, 32'h2222, 0, 0);
        #1;
        chk("post_rst_alu_r", 102, 32'(o_alu_ready), 32'h1);
        chk("post_rst_lsu_r", 102, 32'(o_lsu_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("post_rst_wa", 102, 32'(o_write_addr), 32'd21);
        chk("post_rst_wd", 102, o_write_data, 32'h2121);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("post_rst_wf_drop", 103, 32'(o_write_flag), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
